// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: word load/store over a req/ack bus, one writeback beat per op.
// Latency 1 for non-memory/misaligned ops, 2 + ack-wait for bus ops; ex_ready low while a bus op is outstanding.
module mem_access_stage #(
  parameter int SIZE           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [SIZE-1:0] alu_result,
  input  logic [SIZE-1:0] store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic [4:0]      rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            wb_valid,
  output logic [SIZE-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            err_misalign,
  output logic            err_timeout
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            regw_q, regw_d;
  logic            wb_valid_q, wb_valid_d;
  logic [SIZE-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic            err_mis_q, err_mis_d;
  logic            err_to_q, err_to_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rd_d           = rd_q;
    regw_d         = regw_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    err_mis_d      = 1'b0;
    err_to_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!(mem_read || mem_write)) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = alu_result;
            wb_rd_d        = rd;
            wb_reg_write_d = reg_write;
          end else if (alu_result[1:0] != 2'b00) begin
            wb_valid_d     = 1'b1;
            err_mis_d      = 1'b1;
            wb_data_d      = alu_result;
            wb_rd_d        = rd;
            wb_reg_write_d = 1'b0;
          end else begin
            // store wins when both read and write are flagged
            state_d     = WAIT;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = mem_write;
            mem_addr_d  = alu_result;
            mem_wdata_d = store_data;
            rd_d        = rd;
            regw_d      = reg_write;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_data_d      = mem_we_q ? mem_addr_q : mem_rdata;
          wb_reg_write_d = mem_we_q ? 1'b0 : regw_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = IDLE;
          cnt_d          = 8'd0;
          mem_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          err_to_d       = 1'b1;
          wb_rd_d        = rd_q;
          wb_data_d      = mem_addr_q;
          wb_reg_write_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rd_q           <= 5'd0;
      regw_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      err_mis_q      <= 1'b0;
      err_to_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rd_q           <= rd_d;
      regw_q         <= regw_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      err_mis_q      <= err_mis_d;
      err_to_q       <= err_to_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 4-cycle bus timeout; inputs driven and outputs sampled on negedge.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_result, store_data;
  logic        mem_read, mem_write, reg_write;
  logic [4:0]  rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, err_misalign, err_timeout;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  mem_access_stage #(.SIZE(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic rdn,
                       input logic wr, input logic rw, input logic [4:0] r);
    ex_valid = 1'b1; alu_result = a; store_data = sd;
    mem_read = rdn; mem_write = wr; reg_write = rw; rd = r;
    step();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; alu_result = '0; store_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; rd = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    #12;
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // pass-through
    issue(32'h14, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8);
    chk("pt_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("pt_wb_data", wb_data, 32'h14);
    chk("pt_wb_rd", {27'd0, wb_rd}, 32'd8);
    chk("pt_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    chk("pt_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("pt_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("pt_wb_pulse", {31'd0, wb_valid}, 32'd0);
    chk("pt_wb_hold", wb_data, 32'h14);

    // mem_ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    step();
    chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_data", wb_data, 32'h14);

    // load, ack in 4th WAIT cycle
    issue(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", {31'd0, mem_req}, 32'd1);
      chk("ld_addr", mem_addr, 32'h100);
      chk("ld_we", {31'd0, mem_we}, 32'd0);
      chk("ld_ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("ld_no_wb", {31'd0, wb_valid}, 32'd0);
      step();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_wb_rd", {27'd0, wb_rd}, 32'd9);
    chk("ld_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    chk("ld_err_to", {31'd0, err_timeout}, 32'd0);
    chk("ld_ex_ready", {31'd0, ex_ready}, 32'd1);

    // store (both read and write set: store wins), ack on first WAIT cycle
    issue(32'h200, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 5'd5);
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'h1234_5678);
    chk("st_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("st_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("st_wb_data", wb_data, 32'h200);
    chk("st_req_drop", {31'd0, mem_req}, 32'd0);

    // misaligned load
    issue(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3);
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_err", {31'd0, err_misalign}, 32'd1);
    chk("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("mis_wb_data", wb_data, 32'h102);
    chk("mis_wb_rd", {27'd0, wb_rd}, 32'd3);
    step();
    chk("mis_err_pulse", {31'd0, err_misalign}, 32'd0);
    chk("mis_req_after", {31'd0, mem_req}, 32'd0);

    // timeout: no ack
    issue(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
    req_cycles = 0;
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) begin
      req_cycles++;
      step();
    end
    chk("to_req_cycles", req_cycles, 32'd4);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    step();
    chk("to_err_pulse", {31'd0, err_timeout}, 32'd0);

    // ack exactly on the final count wins
    issue(32'h304, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6);
    step(); step(); step();
    chk("to4_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    step();
    mem_ack = 1'b0;
    chk("to4_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to4_err", {31'd0, err_timeout}, 32'd0);
    chk("to4_wb_data", wb_data, 32'hCAFE_0001);
    chk("to4_wb_rw", {31'd0, wb_reg_write}, 32'd1);

    // reset two cycles into WAIT
    issue(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_req", {31'd0, mem_req}, 32'd0);
    chk("rstw_ex_ready", {31'd0, ex_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstw_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    issue(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4);
    chk("rstw_pt_valid", {31'd0, wb_valid}, 32'd1);
    chk("rstw_pt_data", wb_data, 32'h55);
    chk("rstw_pt_rd", {27'd0, wb_rd}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the MIPS pipeline. It consumes Execute-stage results (ALU result, store data, control bits).
- Performs word loads and stores to the external data memory over a req/ack handshake, and presents a single writeback beat to the register-file writer.
- Stalls upstream via ex_ready while a bus transaction is outstanding. Flags misaligned accesses and bus timeouts.

Parameters:
- SIZE, 32, data/address width.
- TIMEOUT_CYCLES, 16, consecutive WAIT cycles without mem_ack before the access is aborted (legal range 2..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  Execute result valid this cycle.
- ex_ready  out  1  stage can accept; equals (state==IDLE).
- alu_result  in  SIZE  ALU result; used as byte address for memory ops.
- store_data  in  SIZE  ReadData2 forwarded for stores.
- mem_read  in  1  load instruction.
- mem_write  in  1  store instruction.
- reg_write  in  1  instruction writes the register file.
- rd  in  5  destination register.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  1=store, 0=load; stable while mem_req.
- mem_addr  out  SIZE  word-aligned address; stable while mem_req.
- mem_wdata  out  SIZE  store data; stable while mem_req.
- mem_rdata  in  SIZE  load data; valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion strobe.
- wb_valid  out  1  one-cycle writeback beat.
- wb_data  out  SIZE  load data or pass-through ALU result.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  qualified register write enable.
- err_misalign  out  1  one-cycle pulse, aligned with wb_valid.
- err_timeout  out  1  one-cycle pulse, aligned with wb_valid.

Behaviour:
- Reset (rst_n=0, async):
  - State=IDLE; timeout counter=0.
  - All registered outputs forced to 0: mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_rd, wb_reg_write, err_*.
  - ex_ready=1 (combinational from IDLE).
  - Reset mid-transaction drops mem_req immediately; no wb beat is produced for the aborted access.
- States: IDLE, WAIT.
- Accept occurs when ex_valid && ex_ready at a clock edge.
- If both mem_write and mem_read are set, mem_write wins (treated as a store).
- Accept, non-memory op:
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write.
  - Latency 1; stays in IDLE, so back-to-back accepts give a wb beat every cycle.
- Accept, memory op with alu_result[1:0]!=0:
  - No bus request.
  - Next cycle: wb_valid=1, err_misalign=1, wb_reg_write=0, wb_rd=rd, wb_data=alu_result.
  - Stays in IDLE.
- Accept, aligned memory op:
  - Register address, data, we, rd and reg_write; go to WAIT.
  - Next cycle: mem_req=1, counter=0.
- In WAIT:
  - ex_ready=0; upstream holds its inputs.
  - mem_req/addr/we/wdata do not change.
  - Counter increments every cycle in which mem_ack=0.
- mem_ack=1 in WAIT:
  - Capture mem_rdata; return to IDLE.
  - Next cycle: mem_req=0, wb_valid=1.
    - Load: wb_data=captured rdata, wb_reg_write=registered reg_write.
    - Store: wb_data=address, wb_reg_write=0.
  - ex_ready is 1 in that same cycle. Accept-to-wb latency = 2 + ack wait cycles (ack on first WAIT cycle gives 2).
- Timeout: counter reaches TIMEOUT_CYCLES with mem_ack=0.
  - Abort and return to IDLE.
  - Next cycle: mem_req=0, wb_valid=1, err_timeout=1, wb_reg_write=0.
  - mem_ack on the same edge as the final count: ack wins, no timeout.
- mem_ack while in IDLE is ignored; no state or output change.
- wb_valid, err_misalign and err_timeout are single-cycle pulses; they are 0 in every cycle without a beat.
- wb_data/wb_rd hold their last value between beats.
- Address is passed unmodified as a byte address; no byte enables (word access only).

Test Plan:
- Reset then pass-through: accept alu_result=0x0000_0014, rd=8, reg_write=1, no mem -> next cycle wb_valid=1, wb_data=0x14, wb_rd=8, wb_reg_write=1; ex_ready stays 1; mem_req never asserted.
- Load: alu_result=0x0000_0100, mem_read=1, rd=9; memory model acks 3 cycles after mem_req rises with rdata=0xDEAD_BEEF.
  - mem_addr=0x100, mem_we=0 held stable throughout; ex_ready=0 in WAIT.
  - wb beat the cycle after ack: wb_data=0xDEAD_BEEF, wb_rd=9, wb_reg_write=1.
- Store: alu_result=0x200, store_data=0x1234_5678, mem_write=1, reg_write=1; ack on first WAIT cycle.
  - mem_we=1, mem_wdata=0x1234_5678.
  - wb_valid two cycles after accept with wb_reg_write=0.
- Misaligned: mem_read=1, alu_result=0x102 -> mem_req stays 0; next cycle wb_valid=1, err_misalign=1, wb_reg_write=0.
- Timeout: TIMEOUT_CYCLES=4, load with no ack -> mem_req high exactly 4 cycles, then low; err_timeout=1 with wb_valid; repeat with ack in the 4th WAIT cycle -> normal load, err_timeout=0.
- Reset mid-WAIT: assert rst_n=0 two cycles into WAIT -> mem_req falls without a clock edge; no wb_valid after release; ex_ready=1; next accepted op behaves normally.
